// File: rtl/timer_multi_if.sv
// CPU-side register bus of the multi-channel timer: address, data in/out,
// read/write strobe, chip select and the shared interrupt line.
interface timer_multi_if #(
  parameter int CH_BITS = 1
);
  logic [2+CH_BITS:0] AD;
  logic [7:0]         DI;
  logic [7:0]         DO;
  logic               rw;
  logic               cs;
  logic               intr;

  modport master (output AD, DI, rw, cs, input DO, intr);
  modport slave  (input AD, DI, rw, cs, output DO, intr);
endinterface

// File: rtl/timer_multi.sv
// Multi-channel down-counting timer: per-channel 8-bit prescaler, reload,
// one-shot/periodic mode and sticky interrupt flag, ORed onto one intr line.
module timer_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int CH_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  timer_multi_if.slave  bus
);
  localparam int AW = 3 + CH_BITS;

  logic [CHANNELS-1:0] r_en, r_mode, r_ie, r_if;
  logic [WIDTH-1:0]    r_reload [CHANNELS];
  logic [WIDTH-1:0]    r_count  [CHANNELS];
  logic [7:0]          r_stage  [CHANNELS];
  logic [7:0]          r_shadow [CHANNELS];
  logic [7:0]          r_presc  [CHANNELS];
  logic [7:0]          r_pc     [CHANNELS];

  logic [CH_BITS-1:0]  w_ch;
  logic [2:0]          w_off;
  logic                w_ch_ok, w_wr, w_rd;
  logic [CHANNELS-1:0] w_sel, w_ctrl_wr, w_load, w_pc_hit, w_tick, w_uflow;
  logic [15:0]         w_cnt16  [CHANNELS];
  logic [15:0]         w_rld16  [CHANNELS];
  logic [7:0]          w_do;

  function automatic logic [WIDTH-1:0] fit(input logic [15:0] v);
    return v[WIDTH-1:0];
  endfunction

  function automatic logic [15:0] widen(input logic [WIDTH-1:0] v);
    logic [15:0] r;
    r = 16'h0000;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign w_ch    = bus.AD[AW-1:3];
  assign w_off   = bus.AD[2:0];
  assign w_ch_ok = (int'(w_ch) < CHANNELS);
  assign w_wr    = bus.cs & ~bus.rw;
  assign w_rd    = bus.cs & bus.rw;

  // A CTRL write that clears EN, or a LOAD, swallows a coincident tick.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_sel[c]     = w_ch_ok && (int'(w_ch) == c);
      w_ctrl_wr[c] = w_wr && w_sel[c] && (w_off == 3'd0);
      w_load[c]    = w_ctrl_wr[c] && bus.DI[3];
      w_pc_hit[c]  = r_pc[c] == r_presc[c];
      w_tick[c]    = r_en[c] && w_pc_hit[c] && !(w_ctrl_wr[c] && !bus.DI[0]) && !w_load[c];
      w_uflow[c]   = w_tick[c] && (r_count[c] == '0);
      w_cnt16[c]   = widen(r_count[c]);
      w_rld16[c]   = widen(r_reload[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= '0;
      r_mode <= '0;
      r_ie   <= '0;
      r_if   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_reload[c] <= '0;
        r_count[c]  <= '0;
        r_stage[c]  <= 8'h00;
        r_shadow[c] <= 8'h00;
        r_presc[c]  <= 8'h00;
        r_pc[c]     <= 8'h00;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_load[c] || (w_ctrl_wr[c] && bus.DI[0] && !r_en[c])) begin
          r_pc[c] <= 8'h00;
        end else if (r_en[c]) begin
          r_pc[c] <= w_pc_hit[c] ? 8'h00 : r_pc[c] + 8'h01;
        end

        // Periodic reload samples RELOAD before any same-edge commit lands.
        if (w_load[c]) begin
          r_count[c] <= r_reload[c];
        end else if (w_tick[c]) begin
          if (r_count[c] != '0) begin
            r_count[c] <= r_count[c] - WIDTH'(1);
          end else if (r_mode[c]) begin
            r_count[c] <= r_reload[c];
          end
        end

        if (w_ctrl_wr[c]) begin
          r_en[c]   <= bus.DI[0];
          r_mode[c] <= bus.DI[1];
          r_ie[c]   <= bus.DI[2];
        end else if (w_uflow[c] && !r_mode[c]) begin
          r_en[c] <= 1'b0;
        end

        if (w_uflow[c]) begin
          r_if[c] <= 1'b1;
        end else if (w_wr && w_sel[c] && (w_off == 3'd1) && bus.DI[0]) begin
          r_if[c] <= 1'b0;
        end

        if (w_wr && w_sel[c]) begin
          case (w_off)
            3'd2:    r_stage[c]  <= bus.DI;
            3'd3:    r_reload[c] <= fit({bus.DI, r_stage[c]});
            3'd6:    r_presc[c]  <= bus.DI;
            default: ;
          endcase
        end

        if (w_rd && w_sel[c] && (w_off == 3'd4)) begin
          r_shadow[c] <= w_cnt16[c][15:8];
        end
      end
    end
  end

  // Read mux, gated by chip select and a valid channel.
  always_comb begin
    w_do = 8'h00;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.cs && w_sel[c]) begin
        case (w_off)
          3'd0:    w_do = {5'b00000, r_ie[c], r_mode[c], r_en[c]};
          3'd1:    w_do = {6'b000000, r_en[c], r_if[c]};
          3'd2:    w_do = w_rld16[c][7:0];
          3'd3:    w_do = w_rld16[c][15:8];
          3'd4:    w_do = w_cnt16[c][7:0];
          3'd5:    w_do = r_shadow[c];
          3'd6:    w_do = r_presc[c];
          default: w_do = 8'h00;
        endcase
      end else begin
        w_do = w_do;
      end
    end
  end

  assign bus.DO   = w_do;
  assign bus.intr = |(r_if & r_ie);
endmodule

// File: doc/timer_multi.md
# timer_multi

Parametrised multi-channel down-counting timer peripheral for the microcpu MCU boards. It is the successor of the single-channel timer and sits in the same $FFxx I/O decode window. It provides CHANNELS independent timers, each with:
- an 8-bit prescaler,
- a reload register up to 16 bits,
- one-shot or periodic mode,
- a sticky interrupt flag.

Channel interrupts are ORed onto the single CPU `intr` line.

## Interface
Parameters:
- CHANNELS, 2, number of timer channels (1..4).
- WIDTH, 16, counter/reload width in bits (1..16).
- CH_BITS, 1, address bits selecting the channel; must be ≥ clog2(CHANNELS), minimum 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- AD  in  3+CH_BITS  register address; AD[2:0] is the register offset, upper bits select the channel.
- DI  in  8  write data from CPU.
- DO  out  8  read data; combinational from registers; 0 when cs=0.
- rw  in  1  1 = read, 0 = write.
- cs  in  1  chip select; write occurs on each clk edge with cs=1, rw=0.
- intr  out  1  OR over channels of (IF & IE); reset 0.

## Operation
Per-channel register map (offset = AD[2:0]):
- 0 CTRL, read/write:
  - bit0 EN.
  - bit1 MODE: 0 = one-shot, 1 = periodic.
  - bit2 IE.
  - bit3 LOAD: write-1 strobe, always reads 0.
  - Bits 7:4 read 0.
- 1 STATUS:
  - bit0 IF: sticky; write 1 clears.
  - bit1 RUN: read-only copy of EN.
  - Other bits read 0; writing 0 to IF has no effect.
- 2 RELOAD_LO: write goes to a per-channel staging byte; read returns RELOAD[7:0].
- 3 RELOAD_HI: write commits {DI, staging} into RELOAD atomically; read returns RELOAD[15:8].
- 4 COUNT_LO: read-only. Returns COUNT[7:0]; every read cycle also snapshots COUNT[15:8] into a shadow byte.
- 5 COUNT_HI: read-only; returns the shadow byte.
- 6 PRESCALE: 8-bit P, read/write.
- 7: reserved; reads 0, writes ignored.

General rules:
- Bits at or above WIDTH in RELOAD/COUNT read 0 and are discarded on write.
- A channel select ≥ CHANNELS reads 0 and ignores writes.

Counting, per channel, each clk edge with EN=1:
- Prescaler pc: if pc == P, a tick is generated and pc ← 0; otherwise pc ← pc+1.
- On a tick with COUNT ≠ 0: COUNT ← COUNT−1.
- On a tick with COUNT = 0 (underflow):
  - IF ← 1.
  - MODE=1: COUNT ← RELOAD.
  - MODE=0: EN ← 0 and COUNT stays 0.
- With EN=0: pc and COUNT hold.

Writes to CTRL:
- Writing CTRL with EN 0→1 resets pc to 0.
- LOAD=1: COUNT ← RELOAD and pc ← 0, applied regardless of EN.

Reset: every register, staging byte, shadow byte, pc, COUNT and RELOAD go to 0; DO=0, intr=0.

Simultaneous-event priorities, all in the same cycle:
- LOAD vs. tick: LOAD wins and no decrement occurs.
- IF clear write vs. underflow: set wins, so IF stays 1.
- CTRL write clearing EN vs. tick: the tick is discarded.
- One-shot underflow vs. a CTRL write setting EN: the CPU write wins.
- RELOAD_HI commit vs. periodic underflow: the reload uses the old RELOAD value; the new value takes effect from the next reload.

Wrap-around:
- RELOAD = 0, periodic: underflow every P+1 cycles.
- P = 0: a tick every enabled cycle.

## Timing
- Write latency: one edge. A register written at edge k reads back its new value after edge k.
- IF is set at the underflow edge; intr goes high combinationally from the IF/IE flops in the same cycle after that edge.
- Enable at edge E with COUNT = N, prescale P:
  - First tick at edge E+(P+1).
  - Underflow at edge E+(N+1)(P+1).
- Periodic period is (RELOAD+1)(P+1) cycles.
- Asynchronous rst mid-count: all outputs drop to 0 immediately; counting resumes only after software re-enables the channel.

## Test plan
- Reset: assert rst asynchronously mid-count → DO=0, intr=0 immediately; all registers read 0 after release.
- One-shot, ch0: RELOAD=$0003, P=0, LOAD+EN+IE (CTRL=$0D) → IF and intr set exactly 4 cycles after the write edge; EN reads 0; COUNT reads 0.
- Periodic, ch1: RELOAD=$0102, P=3, MODE=1, IE=1 → intr every 259×4=1036 cycles; write STATUS=$01 clears intr until the next underflow.
- Prescaler/atomicity: while ch0 runs with COUNT crossing $0100→$00FF, read LO then HI → the pair is consistent ($00FF or $0100, never $01FF/$0000 torn).
- Collisions: write STATUS=$01 on the underflow edge → IF remains 1. Issue LOAD on a tick edge → COUNT=RELOAD with no decrement.
- Parameter sweep: CHANNELS=4, WIDTH=8 → RELOAD_HI reads 0, channel 3 independent of channel 0, intr is the OR of both channels' flags.
